// File: rtl/i_des_align.sv
// Serial-to-parallel deserializer with bitslip word alignment and an optional
// training FSM that slips until ALIGN_PATTERN is seen LOCK_COUNT times in a row.
module i_des_align #(
    parameter int          WIDTH         = 8,
    parameter logic [9:0]  ALIGN_PATTERN = 10'h0B5,
    parameter int          LOCK_COUNT    = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             D,
    input  logic             EN,
    input  logic             BITSLIP,
    input  logic             TRAIN,
    output logic [WIDTH-1:0] Q,
    output logic             DATA_VALID,
    output logic             ALIGNED,
    output logic [3:0]       BITSLIP_CNT,
    output logic [1:0]       FSM_STATE
);

    if (WIDTH < 3 || WIDTH > 10) begin : g_bad_width
        $error("i_des_align: WIDTH must be in 3..10");
    end
    if (LOCK_COUNT < 1 || LOCK_COUNT > 15) begin : g_bad_lock
        $error("i_des_align: LOCK_COUNT must be in 1..15");
    end

    localparam logic [WIDTH-1:0] PAT    = ALIGN_PATTERN[WIDTH-1:0];
    localparam logic [3:0]       LAST   = 4'(WIDTH - 1);
    localparam logic [3:0]       LOCK_N = 4'(LOCK_COUNT);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sreg;
    logic [3:0]       bitcnt;
    logic [3:0]       match_cnt;
    logic             slip_pending;
    logic             lockout;
    logic             bitslip_q;
    logic             train_q;
    logic             auto_slip;

    logic             slip_req;
    logic             lock_blocks;
    logic [WIDTH-1:0] word_next;

    // DATA_VALID is a one-cycle strobe with no backpressure: Q is new exactly
    // in the cycle DATA_VALID=1 and holds its value at all other times.
    assign slip_req    = (BITSLIP & ~bitslip_q) | auto_slip;
    assign lock_blocks = lockout & ~DATA_VALID;
    assign word_next   = {sreg[WIDTH-2:0], D};
    assign FSM_STATE   = state;

    // Data path: a slip shifts a bit without counting it, stretching the word.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sreg         <= '0;
            bitcnt       <= '0;
            Q            <= '0;
            DATA_VALID   <= 1'b0;
            BITSLIP_CNT  <= '0;
            slip_pending <= 1'b0;
            lockout      <= 1'b0;
            bitslip_q    <= 1'b0;
        end else begin
            bitslip_q  <= BITSLIP;
            DATA_VALID <= 1'b0;
            if (DATA_VALID) begin
                lockout <= 1'b0;
            end
            if (slip_req && !lock_blocks) begin
                slip_pending <= 1'b1;
            end
            if (EN) begin
                sreg <= word_next;
                if (slip_pending) begin
                    slip_pending <= 1'b0;
                    lockout      <= 1'b1;
                    BITSLIP_CNT  <= (BITSLIP_CNT == LAST) ? 4'd0 : BITSLIP_CNT + 4'd1;
                end else if (bitcnt == LAST) begin
                    Q          <= word_next;
                    DATA_VALID <= 1'b1;
                    bitcnt     <= '0;
                end else begin
                    bitcnt <= bitcnt + 4'd1;
                end
            end
        end
    end

    // Training FSM: judges each new word while DATA_VALID is high.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= ST_IDLE;
            match_cnt <= '0;
            auto_slip <= 1'b0;
            ALIGNED   <= 1'b0;
            train_q   <= 1'b0;
        end else begin
            train_q   <= TRAIN;
            auto_slip <= 1'b0;
            case (state)
                ST_IDLE: begin
                    ALIGNED <= 1'b0;
                    if (TRAIN) begin
                        state     <= ST_SEARCH;
                        match_cnt <= '0;
                    end
                end
                ST_SEARCH: begin
                    if (!TRAIN) begin
                        state     <= ST_IDLE;
                        match_cnt <= '0;
                    end else if (DATA_VALID) begin
                        if (Q == PAT) begin
                            if (match_cnt + 4'd1 == LOCK_N) begin
                                state     <= ST_LOCKED;
                                ALIGNED   <= 1'b1;
                                match_cnt <= '0;
                            end else begin
                                match_cnt <= match_cnt + 4'd1;
                            end
                        end else begin
                            match_cnt <= '0;
                            auto_slip <= 1'b1;
                        end
                    end
                end
                ST_LOCKED: begin
                    // Only a fresh TRAIN request restarts training; a held level does not.
                    if (TRAIN && !train_q) begin
                        state     <= ST_SEARCH;
                        ALIGNED   <= 1'b0;
                        match_cnt <= '0;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    ALIGNED <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i_des_align.sv
// Bench for i_des_align: a bit-history reference model checked every cycle,
// directed scenarios with literal expectations, then a randomized soak.
module tb_i_des_align;

    localparam int             W    = 8;
    localparam int             LOCK = 4;
    localparam logic [W-1:0]   PAT  = 8'hB5;

    logic         CLK = 1'b0;
    logic         RST = 1'b0;
    logic         D = 1'b0;
    logic         EN = 1'b0;
    logic         BITSLIP = 1'b0;
    logic         TRAIN = 1'b0;
    logic [W-1:0] Q;
    logic         DATA_VALID;
    logic         ALIGNED;
    logic [3:0]   BITSLIP_CNT;
    logic [1:0]   FSM_STATE;

    i_des_align #(
        .WIDTH        (W),
        .ALIGN_PATTERN(10'h0B5),
        .LOCK_COUNT   (LOCK)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .D          (D),
        .EN         (EN),
        .BITSLIP    (BITSLIP),
        .TRAIN      (TRAIN),
        .Q          (Q),
        .DATA_VALID (DATA_VALID),
        .ALIGNED    (ALIGNED),
        .BITSLIP_CNT(BITSLIP_CNT),
        .FSM_STATE  (FSM_STATE)
    );

    // ---------------- clock ----------------
    always #5 CLK = ~CLK;

    // ---------------- bookkeeping ----------------
    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- driver ----------------
    logic [W-1:0] stream_word = PAT;
    int           sp = 0;
    bit           use_rand_d = 1'b0;
    bit           flip = 1'b0;

    task automatic drive(input bit r, input bit e, input bit b, input bit t);
        @(posedge CLK);
        #1;
        RST     = r;
        EN      = e;
        BITSLIP = b;
        TRAIN   = t;
        if (e && !use_rand_d) begin
            D = stream_word[W-1-(sp % W)] ^ flip;
            sp++;
        end else begin
            D = 1'($urandom);
        end
    endtask

    logic [W-1:0] dv_q_log[$];
    int           dv_cyc_log[$];

    task automatic do_reset(input bit t);
        drive(1'b1, 1'b0, 1'b0, t);
        drive(1'b1, 1'b0, 1'b0, t);
        dv_q_log.delete();
        dv_cyc_log.delete();
        sp = 0;
    endtask

    function automatic int log_q(input int k);
        return (k >= 0 && k < dv_q_log.size()) ? int'(dv_q_log[k]) : -1;
    endfunction

    function automatic int log_cyc(input int k);
        return (k >= 0 && k < dv_cyc_log.size()) ? dv_cyc_log[k] : -1000;
    endfunction

    // ---------------- reference model ----------------
    // Words are the last W received bits; a slip is a received bit that does
    // not count toward the W bits that make up the next word.
    int           cyc = 0;
    int           rst_cyc = 0;
    bit           m_valid = 1'b0;
    logic [W-1:0] m_q;
    bit           m_dv, m_aligned, m_pending, m_lockout, m_auto, m_prev_bs, m_prev_tr;
    int           m_cnt, m_counted, m_mode, m_match;
    bit           hist[$];

    always @(posedge CLK) begin
        bit           req, blocked, nxt_pending, nxt_auto, nxt_dv;
        logic [W-1:0] w;
        cyc++;
        if (RST) begin
            m_valid   = 1'b1;
            rst_cyc   = cyc;
            m_q       = '0;
            m_dv      = 1'b0;
            m_aligned = 1'b0;
            m_pending = 1'b0;
            m_lockout = 1'b0;
            m_auto    = 1'b0;
            m_prev_bs = 1'b0;
            m_prev_tr = 1'b0;
            m_cnt     = 0;
            m_counted = 0;
            m_mode    = 0;
            m_match   = 0;
            hist.delete();
        end else if (m_valid) begin
            req      = (BITSLIP && !m_prev_bs) || m_auto;
            blocked  = m_lockout && !m_dv;
            nxt_auto = 1'b0;
            case (m_mode)
                0: if (TRAIN) begin m_mode = 1; m_match = 0; end
                1: begin
                    if (!TRAIN) begin
                        m_mode  = 0;
                        m_match = 0;
                    end else if (m_dv) begin
                        if (m_q == PAT) begin
                            m_match++;
                            if (m_match == LOCK) begin m_mode = 2; m_match = 0; end
                        end else begin
                            m_match  = 0;
                            nxt_auto = 1'b1;
                        end
                    end
                end
                default: if (TRAIN && !m_prev_tr) begin m_mode = 1; m_match = 0; end
            endcase
            m_aligned = (m_mode == 2);
            if (m_dv) m_lockout = 1'b0;
            nxt_pending = m_pending || (req && !blocked);
            nxt_dv = 1'b0;
            if (EN) begin
                hist.push_back(D);
                if (hist.size() > W) void'(hist.pop_front());
                if (m_pending) begin
                    nxt_pending = 1'b0;
                    m_lockout   = 1'b1;
                    m_cnt       = (m_cnt + 1) % W;
                end else begin
                    m_counted++;
                    if (m_counted == W) begin
                        w = '0;
                        foreach (hist[i]) w = {w[W-2:0], hist[i]};
                        m_q       = w;
                        nxt_dv    = 1'b1;
                        m_counted = 0;
                    end
                end
            end
            m_pending = nxt_pending;
            m_dv      = nxt_dv;
            m_auto    = nxt_auto;
            m_prev_bs = BITSLIP;
            m_prev_tr = TRAIN;
        end
    end

    // ---------------- scoreboard / compare ----------------
    always @(negedge CLK) begin
        if (m_valid) begin
            chk("q", int'(Q), int'(m_q));
            chk("data_valid", int'(DATA_VALID), int'(m_dv));
            chk("aligned", int'(ALIGNED), int'(m_aligned));
            chk("bitslip_cnt", int'(BITSLIP_CNT), m_cnt);
            if (DATA_VALID) begin
                dv_q_log.push_back(Q);
                dv_cyc_log.push_back(cyc);
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [W-1:0] exp_q[$];
    bit           tr_r;

    initial begin
        // Aligned stream, no slips.
        do_reset(1'b0);
        repeat (40) drive(1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge CLK);
        chk("p1_first_latency", log_cyc(0) - rst_cyc, 8);
        chk("p1_period", log_cyc(1) - log_cyc(0), 8);
        chk("p1_first_word", log_q(0), 'hB5);
        chk("p1_last_word", log_q(dv_q_log.size() - 1), 'hB5);
        chk("p1_slips", int'(BITSLIP_CNT), 0);

        // One user slip mid-word, second edge in the same word ignored.
        do_reset(1'b0);
        repeat (18) drive(1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        repeat (40) drive(1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge CLK);
        chk("p2_stretched_period", log_cyc(2) - log_cyc(1), 9);
        chk("p2_slipped_word", log_q(2), 'h6B);
        chk("p2_last_word", log_q(dv_q_log.size() - 1), 'h6B);
        chk("p2_slips", int'(BITSLIP_CNT), 1);

        // EN toggling every cycle.
        do_reset(1'b0);
        for (int i = 0; i < 80; i++) drive(1'b0, (i % 2) == 0, 1'b0, 1'b0);
        @(negedge CLK);
        chk("p3_first_latency", log_cyc(0) - rst_cyc, 15);
        chk("p3_period", log_cyc(1) - log_cyc(0), 16);
        chk("p3_word0", log_q(0), 'hB5);
        chk("p3_word1", log_q(1), 'hB5);

        // Training from a stream that reads 0xAD.
        do_reset(1'b1);
        sp = 3;
        repeat (8 * 14) drive(1'b0, 1'b1, 1'b0, 1'b1);
        @(negedge CLK);
        exp_q = '{8'hAD, 8'h5B, 8'hB6, 8'h6D, 8'hDA, 8'hB5, 8'hB5, 8'hB5, 8'hB5};
        foreach (exp_q[i]) chk($sformatf("p4_word%0d", i), log_q(i), int'(exp_q[i]));
        chk("p4_aligned", int'(ALIGNED), 1);
        chk("p4_slips", int'(BITSLIP_CNT), 5);

        // Locked behaviour: TRAIN drop, corrupted word, retrain.
        repeat (16) drive(1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge CLK);
        chk("p5_aligned_train_low", int'(ALIGNED), 1);
        flip = 1'b1;
        repeat (8) drive(1'b0, 1'b1, 1'b0, 1'b0);
        flip = 1'b0;
        repeat (24) drive(1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge CLK);
        chk("p5_aligned_after_corrupt", int'(ALIGNED), 1);
        chk("p5_no_slip_when_locked", int'(BITSLIP_CNT), 5);
        repeat (3) drive(1'b0, 1'b1, 1'b0, 1'b1);
        @(negedge CLK);
        chk("p5_retrain_unaligned", int'(ALIGNED), 0);
        repeat (60) drive(1'b0, 1'b1, 1'b0, 1'b1);
        @(negedge CLK);
        chk("p5_relocked", int'(ALIGNED), 1);
        chk("p5_relock_slips", int'(BITSLIP_CNT), 5);

        // Reset mid-word while searching.
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        sp = 1;
        repeat (21) drive(1'b0, 1'b1, 1'b0, 1'b1);
        do_reset(1'b1);
        @(negedge CLK);
        chk("p6_q_zero", int'(Q), 0);
        chk("p6_dv_zero", int'(DATA_VALID), 0);
        chk("p6_aligned_zero", int'(ALIGNED), 0);
        chk("p6_cnt_zero", int'(BITSLIP_CNT), 0);
        repeat (12) drive(1'b0, 1'b1, 1'b0, 1'b1);
        @(negedge CLK);
        chk("p6_full_word_latency", log_cyc(0) - rst_cyc, 8);

        // Randomized soak against the model.
        tr_r = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            if (i % 250 == 0) begin
                use_rand_d = ($urandom_range(0, 2) == 0);
                sp = $urandom_range(0, 7);
            end
            if ($urandom_range(0, 199) == 0) tr_r = ~tr_r;
            drive($urandom_range(0, 599) == 0, $urandom_range(0, 9) < 8,
                  $urandom_range(0, 24) == 0, tr_r);
        end
        use_rand_d = 1'b0;
        repeat (2) drive(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge CLK);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/i_des_align.md
Name: i_des_align

Overview:
- Serial-to-parallel input deserializer with word alignment.
- Sits directly downstream of the differential/single-ended input buffer and consumes the buffer's serial output O on D.
- Assembles WIDTH-bit words MSB-first and moves the word boundary one bit at a time (bitslip), either on user request or under an automatic training state machine that locks to a known pattern.

Parameters:
- WIDTH, 8, word width; legal 3..10. Out-of-range values raise $error at elaboration.
- ALIGN_PATTERN, 8'hB5, training word compared against Q. Only the low WIDTH bits are used.
- LOCK_COUNT, 4, consecutive matching words needed to lock; legal 1..15.

Ports:
- CLK  input  1  clock
- RST  input  1  synchronous reset, active-high
- D  input  1  serial data from input buffer O
- EN  input  1  bit enable; D is sampled only when EN=1
- BITSLIP  input  1  user slip request; rising edge triggers a slip
- TRAIN  input  1  enables automatic alignment
- Q  output  WIDTH  deserialized word
- DATA_VALID  output  1  one-cycle strobe, Q updated
- ALIGNED  output  1  auto-alignment locked
- BITSLIP_CNT  output  4  slips applied, modulo WIDTH

Behaviour:
Reset and data path:
- RST=1 at a CLK edge clears everything: Q=0, DATA_VALID=0, ALIGNED=0, BITSLIP_CNT=0, shift register=0, bit counter=0, slip pending/lockout=0, state=IDLE. RST has priority over every other input, including mid-word.
- On each edge with EN=1: sreg <= {sreg[WIDTH-2:0], D}, so the first received bit ends up as the MSB.
- bitcnt counts 0..WIDTH-1.
- Boundary: EN=1 and bitcnt==WIDTH-1. On a boundary, Q <= {sreg[WIDTH-2:0], D}, DATA_VALID=1 for exactly that next cycle, and bitcnt <= 0.
- Latency: the last bit of a word is visible on Q one cycle after its sampling edge.
- EN=0: no shift, no count, DATA_VALID=0; Q and all state hold.

Bitslip:
- slip_req = rising edge of BITSLIP (BITSLIP registered internally) OR auto_slip from the state machine.
- slip_req sets slip_pending unless lockout=1. If lockout=1, the request is dropped.
- Slip is applied on the next EN=1 edge:
  - the bit is shifted in normally but bitcnt is held (not incremented);
  - slip_pending clears;
  - lockout sets;
  - BITSLIP_CNT <= (BITSLIP_CNT+1) mod WIDTH.
- If that edge is also a boundary, the slip takes precedence and no word is emitted that cycle.
- Net effect: every following word is the previous alignment rotated left by 1.
- lockout clears on the next DATA_VALID, so at most one slip is applied per word.
- A slip requested while EN=0 stays pending until EN=1.

Auto-align FSM (evaluated on DATA_VALID cycles, comparing Q against ALIGN_PATTERN):
- IDLE: ALIGNED=0. TRAIN=1 -> SEARCH, with match_cnt=0.
- SEARCH:
  - Match: match_cnt++. When match_cnt reaches LOCK_COUNT -> LOCKED.
  - Mismatch: match_cnt=0 and assert auto_slip for 1 cycle.
  - TRAIN=0 -> IDLE.
- LOCKED: ALIGNED=1 and no auto slips. Stays LOCKED when TRAIN falls. A rising edge of TRAIN -> SEARCH, with ALIGNED=0 and match_cnt=0.
- External BITSLIP stays functional in all states. In LOCKED it does not clear ALIGNED.

Test Plan:
- Reset, then hold EN=1 with a repeating MSB-first stream of 0xB5 starting on the first post-reset edge -> DATA_VALID first pulses the cycle after the 8th sample, Q=0xB5, then DATA_VALID every 8 cycles. ALIGNED=0 and BITSLIP_CNT=0 throughout.
- Same stream, one BITSLIP pulse mid-word -> the current word is stretched to 9 samples; all later words read Q=0x6B; BITSLIP_CNT=1. A second BITSLIP edge within the same word is ignored, so BITSLIP_CNT stays 1.
- EN toggling 1/0 every cycle with a 0xB5 stream -> DATA_VALID every 16 cycles, Q=0xB5. Q holds between strobes.
- TRAIN=1, stream phase-shifted so that words read 0xAD, LOCK_COUNT=4 -> exactly 5 auto slips, one per word, through the sequence 0x5B, 0xB6, 0x6D, 0xDA, 0xB5. After 4 more matching words ALIGNED=1 and BITSLIP_CNT=5.
- In LOCKED, drop TRAIN -> ALIGNED stays 1. Corrupt one word -> no slip. Pulse TRAIN 0->1 -> ALIGNED=0 and relock follows.
- Assert RST mid-word and mid-SEARCH -> on the next cycle all outputs are 0 and state=IDLE. The next word needs a full 8 samples.
